// File: rtl/rv32_regfile_mp_pkg.sv
// Shared RV32 types and default sizing for the multi-port register file.
// The read-bypass option is selected at build time with RV32_RF_BYPASS_EN.
package pkg_rv32_types;

    localparam int unsigned RV32_XLEN     = 32;
    localparam int unsigned RF_NREGS_DEF  = 32;
    localparam int unsigned RF_NUM_RD_DEF = 4;
    localparam int unsigned RF_NUM_WR_DEF = 2;

    typedef enum logic [0:0] {
        RF_CLEAR,
        RF_READY
    } rf_state_e;

endpackage

// File: rtl/rv32_rf_scoreboard.sv
// Per-register pending-write scoreboard: issue sets, winning writeback clears.
// With RV32_RF_BYPASS_EN a same-cycle write to a read address exposes the post-update bit.
module rv32_rf_scoreboard
    import pkg_rv32_types::*;
#(
    parameter int unsigned NREGS  = RF_NREGS_DEF,
    parameter int unsigned NUM_RD = RF_NUM_RD_DEF,
    parameter int unsigned NUM_WR = RF_NUM_WR_DEF,
    parameter int unsigned AW     = $clog2(NREGS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          upd_en,
    input  logic [NUM_RD-1:0][AW-1:0]     rd_addr,
    output logic [NUM_RD-1:0]             rd_pending,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]     wr_addr,
    input  logic [NUM_WR-1:0]             wr_clr,
    input  logic                          iss_en,
    input  logic [AW-1:0]                 iss_rd
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [NREGS-1:0] clr_vec;

    always_comb begin
        clr_vec = '0;
        // Later ports overwrite earlier ones, so the highest-index writer decides wr_clr.
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wr_addr[w] != '0) begin
                clr_vec[wr_addr[w]] = wr_clr[w];
            end
        end
        pend_d = pend_q & ~clr_vec;
        // A newly issued producer owns the register even if an older one retires now.
        if (iss_en && iss_rd != '0) begin
            pend_d[iss_rd] = 1'b1;
        end
        if (!upd_en) begin
            pend_d = pend_q;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_pending[p] = pend_q[rd_addr[p]];
`ifdef RV32_RF_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (upd_en && wr_en[w] && wr_addr[w] == rd_addr[p] && rd_addr[p] != '0) begin
                    rd_pending[p] = pend_d[rd_addr[p]];
                end
            end
`endif
        end
    end

endmodule

// File: rtl/rv32_regfile_mp.sv
// Multi-port RV32 integer register file with post-reset clear sequence and scoreboard.
// Define RV32_RF_BYPASS_EN to forward same-cycle writes onto the read ports.
module rv32_regfile_mp
    import pkg_rv32_types::*;
#(
    parameter int unsigned XLEN   = RV32_XLEN,
    parameter int unsigned NREGS  = RF_NREGS_DEF,
    parameter int unsigned NUM_RD = RF_NUM_RD_DEF,
    parameter int unsigned NUM_WR = RF_NUM_WR_DEF,
    parameter int unsigned AW     = $clog2(NREGS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_RD-1:0][AW-1:0]     rd_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]             rd_pending,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]     wr_addr,
    input  logic [NUM_WR-1:0][XLEN-1:0]   wr_data,
    input  logic [NUM_WR-1:0]             wr_clr,
    input  logic                          iss_en,
    input  logic [AW-1:0]                 iss_rd,
    output logic                          ready
);

    rf_state_e         state_q;
    logic [AW-1:0]     clr_idx_q;
    logic [XLEN-1:0]   mem_q [NREGS-1:1];
    logic              rf_ready;
    logic [NUM_RD-1:0] sb_pending;

    assign rf_ready = (state_q == RF_READY);
    assign ready    = rf_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= AW'(1);
        end else begin
            case (state_q)
                RF_CLEAR: begin
                    if (clr_idx_q == AW'(NREGS - 1)) begin
                        state_q <= RF_READY;
                    end else begin
                        clr_idx_q <= clr_idx_q + AW'(1);
                    end
                end
                default: state_q <= RF_READY;
            endcase
        end
    end

    // Storage has no reset of its own; the clear walk zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == RF_CLEAR) begin
                mem_q[clr_idx_q] <= '0;
            end else begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && wr_addr[w] != '0) begin
                        mem_q[wr_addr[w]] <= wr_data[w];
                    end
                end
            end
        end
    end

    rv32_rf_scoreboard #(
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .AW     (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_en     (rf_ready),
        .rd_addr    (rd_addr),
        .rd_pending (sb_pending),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_clr     (wr_clr),
        .iss_en     (iss_en),
        .iss_rd     (iss_rd)
    );

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p] = '0;
            if (rf_ready && rd_addr[p] != '0) begin
                rd_data[p] = mem_q[rd_addr[p]];
`ifdef RV32_RF_BYPASS_EN
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && wr_addr[w] == rd_addr[p]) begin
                        rd_data[p] = wr_data[w];
                    end
                end
`endif
            end
            rd_pending[p] = rf_ready && (rd_addr[p] != '0) && sb_pending[p];
        end
    end

endmodule
